// File: rtl/fulladder_serial_ctrl.sv
// Bit-serial adder: one full-adder cell is reused over WIDTH cycles, LSB first,
// with valid/ready handshakes on the operand and result sides.
module fulladder_serial_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             Clk_CI,
   input  logic             Rst_RI,
   input  logic             InValid_SI,
   output logic             InReady_SO,
   input  logic [WIDTH-1:0] OpA_DI,
   input  logic [WIDTH-1:0] OpB_DI,
   input  logic             Cin_DI,
   output logic             OutValid_SO,
   input  logic             OutReady_SI,
   output logic [WIDTH-1:0] Sum_DO,
   output logic             Cout_DO,
   output logic             Busy_SO
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t r_state;
   state_t w_stateNext;

   logic [WIDTH-1:0] r_opA;
   logic [WIDTH-1:0] r_opB;
   logic [WIDTH-1:0] r_sum;
   logic [WIDTH-1:0] r_sumOut;
   logic             r_carry;
   logic             r_coutOut;
   logic [CNT_W-1:0] r_cnt;

   logic             w_faSum;
   logic             w_faCout;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] w_sumShifted;

   fulladder_multiple_models u_fa (
      .i_a    (r_opA[0]),
      .i_b    (r_opB[0]),
      .i_cin  (r_carry),
      .o_sum  (w_faSum),
      .o_cout (w_faCout)
   );

   // New sum bit enters at the MSB; written as a shift so WIDTH=1 needs no special slice.
   assign w_sumShifted = (r_sum >> 1) | (WIDTH'(w_faSum) << (WIDTH - 1));

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      InReady_SO  = (r_state == IDLE);
      OutValid_SO = (r_state == DONE);
      Busy_SO     = (r_state != IDLE);
      case (r_state)
         IDLE: begin
            if (InValid_SI) begin
               w_accept    = 1'b1;
               w_stateNext = RUN;
            end
         end
         RUN: begin
            if (r_cnt == LAST_CNT) begin
               w_last      = 1'b1;
               w_stateNext = DONE;
            end
         end
         DONE: begin
            if (OutReady_SI) begin
               w_stateNext = IDLE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   // Result registers are only loaded on the final RUN edge so the outputs hold
   // their last value through IDLE and the next RUN.
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         r_opA     <= '0;
         r_opB     <= '0;
         r_sum     <= '0;
         r_carry   <= 1'b0;
         r_cnt     <= '0;
         r_sumOut  <= '0;
         r_coutOut <= 1'b0;
      end else if (w_accept) begin
         r_opA   <= OpA_DI;
         r_opB   <= OpB_DI;
         r_carry <= Cin_DI;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_sum   <= w_sumShifted;
         r_opA   <= r_opA >> 1;
         r_opB   <= r_opB >> 1;
         r_carry <= w_faCout;
         r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
         if (w_last) begin
            r_sumOut  <= w_sumShifted;
            r_coutOut <= w_faCout;
         end
      end
   end

   assign Sum_DO  = r_sumOut;
   assign Cout_DO = r_coutOut;

endmodule

// Single-bit full-adder cell time-shared by the serial controller.
module fulladder_multiple_models (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: tb/tb_fulladder_serial_ctrl.sv
// Bench for the serial adder: WIDTH=8 instance against a cycle model, plus
// WIDTH=1 truth-table and WIDTH=16 random sweeps checked against plain addition.
module tb_fulladder_serial_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        inValid8 = 0, outReady8 = 0, cin8 = 0;
   logic [7:0]  opA8 = 0, opB8 = 0;
   logic        inReady8, outValid8, cout8, busy8;
   logic [7:0]  sum8;

   logic        inValid1 = 0, outReady1 = 0, cin1 = 0;
   logic [0:0]  opA1 = 0, opB1 = 0;
   logic        inReady1, outValid1, cout1, busy1;
   logic [0:0]  sum1;

   logic        inValid16 = 0, outReady16 = 0, cin16 = 0;
   logic [15:0] opA16 = 0, opB16 = 0;
   logic        inReady16, outValid16, cout16, busy16;
   logic [15:0] sum16;

   fulladder_serial_ctrl #(.WIDTH(8)) u_dut8 (
      .Clk_CI(clk), .Rst_RI(rst), .InValid_SI(inValid8), .InReady_SO(inReady8),
      .OpA_DI(opA8), .OpB_DI(opB8), .Cin_DI(cin8), .OutValid_SO(outValid8),
      .OutReady_SI(outReady8), .Sum_DO(sum8), .Cout_DO(cout8), .Busy_SO(busy8));

   fulladder_serial_ctrl #(.WIDTH(1)) u_dut1 (
      .Clk_CI(clk), .Rst_RI(rst), .InValid_SI(inValid1), .InReady_SO(inReady1),
      .OpA_DI(opA1), .OpB_DI(opB1), .Cin_DI(cin1), .OutValid_SO(outValid1),
      .OutReady_SI(outReady1), .Sum_DO(sum1), .Cout_DO(cout1), .Busy_SO(busy1));

   fulladder_serial_ctrl #(.WIDTH(16)) u_dut16 (
      .Clk_CI(clk), .Rst_RI(rst), .InValid_SI(inValid16), .InReady_SO(inReady16),
      .OpA_DI(opA16), .OpB_DI(opB16), .Cin_DI(cin16), .OutValid_SO(outValid16),
      .OutReady_SI(outReady16), .Sum_DO(sum16), .Cout_DO(cout16), .Busy_SO(busy16));

   // Transaction-level model of the WIDTH=8 instance: phase 0 idle, 1 computing, 2 holding result.
   int         mPhase = 0;
   int         mLeft  = 0;
   bit         mValid = 0;
   logic [8:0] mPend  = '0;
   logic [7:0] mSum   = '0;
   logic       mCout  = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         mPhase = 0;
         mSum   = '0;
         mCout  = 1'b0;
         mValid = 1;
      end else if (mValid) begin
         case (mPhase)
            0: if (inValid8) begin
                  mPend  = {1'b0, opA8} + {1'b0, opB8} + 9'(cin8);
                  mLeft  = 8;
                  mPhase = 1;
               end
            1: begin
                  mLeft = mLeft - 1;
                  if (mLeft == 0) begin
                     mPhase        = 2;
                     {mCout, mSum} = mPend;
                  end
               end
            default: if (outReady8) mPhase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (mValid) begin
         checks++;
         if ({inReady8, outValid8, busy8, cout8, sum8} !==
             {mPhase == 0, mPhase == 2, mPhase != 0, mCout, mSum}) begin
            errors++;
            $display("[TB] FAIL model8 t=%0t actual rdy=%b vld=%b busy=%b cout=%b sum=%h required rdy=%b vld=%b busy=%b cout=%b sum=%h",
                     $time, inReady8, outValid8, busy8, cout8, sum8,
                     mPhase == 0, mPhase == 2, mPhase != 0, mCout, mSum);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic driveIn(input int w, input logic v, input logic [63:0] a, input logic [63:0] b, input logic c);
      case (w)
         1:  begin inValid1 = v;  opA1 = a[0:0];  opB1 = b[0:0];  cin1 = c;  end
         8:  begin inValid8 = v;  opA8 = a[7:0];  opB8 = b[7:0];  cin8 = c;  end
         default: begin inValid16 = v; opA16 = a[15:0]; opB16 = b[15:0]; cin16 = c; end
      endcase
   endtask

   task automatic setReady(input int w, input logic r);
      case (w)
         1: outReady1 = r;
         8: outReady8 = r;
         default: outReady16 = r;
      endcase
   endtask

   function automatic logic getValid(input int w);
      case (w)
         1: return outValid1;
         8: return outValid8;
         default: return outValid16;
      endcase
   endfunction

   function automatic logic getReadyIn(input int w);
      case (w)
         1: return inReady1;
         8: return inReady8;
         default: return inReady16;
      endcase
   endfunction

   function automatic logic getBusy(input int w);
      case (w)
         1: return busy1;
         8: return busy8;
         default: return busy16;
      endcase
   endfunction

   function automatic logic [63:0] getSum(input int w);
      case (w)
         1: return 64'(sum1);
         8: return 64'(sum8);
         default: return 64'(sum16);
      endcase
   endfunction

   function automatic logic getCout(input int w);
      case (w)
         1: return cout1;
         8: return cout8;
         default: return cout16;
      endcase
   endfunction

   // One full operation; result registers rise WIDTH edges after the accept edge
   // (cycle E+WIDTH+1), then held for 'hold' cycles of backpressure.
   task automatic applyStimulus(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic c, input int hold, input string name);
      logic [64:0] total;
      logic [63:0] expSum;
      logic        expCout;
      int          lat;
      total   = {1'b0, a} + {1'b0, b} + 65'(c);
      expSum  = 64'(total & ((65'(1) << w) - 65'(1)));
      expCout = total[w];
      @(negedge clk);
      checkOutput({name, "_inReady"}, 64'(getReadyIn(w)), 64'd1);
      driveIn(w, 1'b1, a, b, c);
      setReady(w, hold == 0);
      @(posedge clk);
      @(negedge clk);
      driveIn(w, 1'b0, '0, '0, 1'b0);
      lat = 0;
      while (!getValid(w) && lat < 200) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      checkOutput({name, "_latency"}, 64'(lat), 64'(w));
      checkOutput({name, "_sum"}, getSum(w), expSum);
      checkOutput({name, "_cout"}, 64'(getCout(w)), 64'(expCout));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput({name, "_holdState"}, {60'd0, getValid(w), getReadyIn(w), getBusy(w), getCout(w)},
                     {60'd0, 1'b1, 1'b0, 1'b1, expCout});
         checkOutput({name, "_holdSum"}, getSum(w), expSum);
      end
      setReady(w, 1'b1);
      @(posedge clk);
      @(negedge clk);
      checkOutput({name, "_release"}, {62'd0, getValid(w), getReadyIn(w)}, {62'd0, 1'b0, 1'b1});
   endtask

   initial begin
      bit seen;
      int lat;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_state", {inReady8, outValid8, busy8, cout8, sum8}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

      applyStimulus(8, 64'h5A, 64'h33, 1'b0, 0, "add_5A_33");
      checkOutput("pin_8D", 64'(sum8), 64'h8D);
      applyStimulus(8, 64'hFF, 64'h01, 1'b0, 0, "add_FF_01");
      checkOutput("pin_carry_wrap", {55'd0, cout8, sum8}, {55'd0, 1'b1, 8'h00});
      applyStimulus(8, 64'hFF, 64'hFF, 1'b1, 0, "add_FF_FF_1");
      checkOutput("pin_all_ones", {55'd0, cout8, sum8}, {55'd0, 1'b1, 8'hFF});
      applyStimulus(8, 64'h00, 64'h00, 1'b0, 0, "add_zero");
      applyStimulus(8, 64'h12, 64'h34, 1'b0, 5, "backpressure");
      checkOutput("pin_46", 64'(sum8), 64'h46);

      // Operands shown during RUN must be ignored.
      @(negedge clk);
      driveIn(8, 1'b1, 64'h21, 64'h13, 1'b0);
      setReady(8, 1'b1);
      @(posedge clk);
      @(negedge clk);
      driveIn(8, 1'b1, 64'hAA, 64'h55, 1'b1);
      repeat (5) @(negedge clk);
      driveIn(8, 1'b0, '0, '0, 1'b0);
      lat = 0;
      while (!outValid8 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("ignore_run_sum", {55'd0, cout8, sum8}, {55'd0, 1'b0, 8'h34});
      seen = 0;
      @(negedge clk);
      repeat (12) begin
         @(negedge clk);
         if (outValid8) seen = 1;
      end
      checkOutput("ignore_run_no_second", 64'(seen), 64'd0);

      // Reset during the 4th RUN cycle discards the operation.
      @(negedge clk);
      driveIn(8, 1'b1, 64'h44, 64'h44, 1'b0);
      @(posedge clk);
      @(negedge clk);
      driveIn(8, 1'b0, '0, '0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_run", {inReady8, outValid8, busy8, cout8, sum8}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (outValid8) seen = 1;
      end
      checkOutput("reset_run_no_valid", 64'(seen), 64'd0);
      applyStimulus(8, 64'h10, 64'h20, 1'b0, 0, "fresh_after_reset");
      checkOutput("pin_30", 64'(sum8), 64'h30);

      // Reset while the result is being presented.
      @(negedge clk);
      driveIn(8, 1'b1, 64'h01, 64'h01, 1'b0);
      setReady(8, 1'b0);
      @(posedge clk);
      @(negedge clk);
      driveIn(8, 1'b0, '0, '0, 1'b0);
      lat = 0;
      while (!outValid8 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_done", {inReady8, outValid8, busy8, cout8, sum8}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      setReady(8, 1'b1);

      // InValid held through DONE: only the output handshake completes first.
      @(negedge clk);
      driveIn(8, 1'b1, 64'h03, 64'h04, 1'b0);
      @(posedge clk);
      @(negedge clk);
      driveIn(8, 1'b1, 64'h05, 64'h06, 1'b0);
      lat = 0;
      while (!outValid8 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("simul_first_sum", 64'(sum8), 64'h07);
      @(negedge clk);
      checkOutput("simul_idle_first", {62'd0, outValid8, inReady8}, {62'd0, 1'b0, 1'b1});
      @(negedge clk);
      driveIn(8, 1'b0, '0, '0, 1'b0);
      checkOutput("simul_accepted", 64'(busy8), 64'd1);
      lat = 0;
      while (!outValid8 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("simul_second_sum", 64'(sum8), 64'h0B);
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         applyStimulus(1, 64'(v[2]), 64'(v[1]), v[0], 0, "w1_truth");
      end
      applyStimulus(1, 64'd1, 64'd1, 1'b1, 0, "w1_pin");
      checkOutput("w1_pin_111", {62'd0, cout1, sum1}, {62'd0, 1'b1, 1'b1});

      for (int i = 0; i < 1000; i++) begin
         applyStimulus(16, 64'($urandom_range(0, 65535)), 64'($urandom_range(0, 65535)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), "w16_rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
